// File: rtl/battleship_shot_engine.sv
// Sequential battleship shot engine: scans a 3x3 or 5x5 window per shot against a fixed fleet.
// Optional macro SHOT_COUNT_EN adds a saturating shots_fired counter output.
module battleship_shot_engine #(
  parameter int GRID      = 10,
  parameter int COORD_W   = 4,
  parameter int BIG_BOMBS = 3,
  parameter int HIT_W     = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               score,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               big,
  output logic               busy,
  output logic               done,
  output logic               wrong,
  output logic               hit,
  output logic               near_miss,
  output logic               miss,
  output logic [4:0]         biggest_ship,
  output logic [4:0]         sunk,
  output logic [HIT_W-1:0]   num_hits,
  output logic [1:0]         big_left,
  output logic               game_over
`ifdef SHOT_COUNT_EN
  ,
  output logic [7:0]         shots_fired
`endif
);

  localparam int MEM_W = $clog2(GRID*GRID);
  localparam logic [COORD_W-1:0] GRID_C = COORD_W'(GRID);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
  state_t state, state_nxt;

  logic [COORD_W-1:0] lx, ly;
  logic               lbig;
  logic signed [2:0]  dx, dy;
  logic               hflag, nflag, wflag;
  logic [4:0]         bflags;
  logic [GRID*GRID-1:0] mem;
  logic [2:0]         dmg [5];
  logic               res_wrong, res_hit, res_near, res_miss, res_go;
  logic [4:0]         res_big, res_sunk;

  function automatic logic [2:0] ship_at(input int cx, input int cy);
    if (cy == 6 && (cx == 7 || cx == 8))             return 3'd0;
    else if (cx == 2 && cy >= 8 && cy <= 10)         return 3'd1;
    else if (cy == 1 && cx >= 2 && cx <= 4)          return 3'd2;
    else if (cy == 2 && cx >= 1 && cx <= 4)          return 3'd3;
    else if (cy == 3 && cx >= 2 && cx <= 6)          return 3'd4;
    else                                             return 3'd7;
  endfunction

  function automatic logic [2:0] ship_size(input int i);
    case (i)
      0:       return 3'd2;
      1, 2:    return 3'd3;
      3:       return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [4:0] top_bit(input logic [4:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++)
      if (v[i]) r = 5'(1) << i;
    return r;
  endfunction

  // Current scan cell, its window role and its fleet membership
  int cxi, cyi, dxi, dyi, lim, mi;
  logic on_board, struck, is_ship, fresh, last, bad_shot;
  logic [2:0] sid;
  logic [MEM_W-1:0] mem_idx;
  logic [4:0] live_sunk;

  always_comb begin
    dxi      = int'(dx);
    dyi      = int'(dy);
    cxi      = int'(lx) + dxi;
    cyi      = int'(ly) + dyi;
    lim      = lbig ? 2 : 1;
    on_board = (cxi >= 1) && (cxi <= GRID) && (cyi >= 1) && (cyi <= GRID);
    mi       = on_board ? (cyi - 1) * GRID + (cxi - 1) : 0;
    mem_idx  = MEM_W'(mi);
    struck   = lbig ? (dxi >= -1 && dxi <= 1 && dyi >= -1 && dyi <= 1)
                    : (dxi == 0 && dyi == 0);
    sid      = ship_at(cxi, cyi);
    is_ship  = on_board && (sid != 3'd7);
    fresh    = is_ship && struck && !mem[mem_idx];
    last     = (dxi == lim) && (dyi == lim);
    bad_shot = (x == '0) || (x > GRID_C) || (y == '0) || (y > GRID_C) ||
               (big && big_left == 2'd0);
    for (int i = 0; i < 5; i++)
      live_sunk[i] = (dmg[i] == ship_size(i));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (score) state_nxt = bad_shot ? REPORT : SCAN;
      SCAN:    if (last) state_nxt = REPORT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem       <= '0;
      for (int i = 0; i < 5; i++) dmg[i] <= '0;
      num_hits  <= '0;
      big_left  <= 2'(BIG_BOMBS);
      wflag     <= 1'b0;
      hflag     <= 1'b0;
      nflag     <= 1'b0;
      bflags    <= '0;
      res_wrong <= 1'b0;
      res_hit   <= 1'b0;
      res_near  <= 1'b0;
      res_miss  <= 1'b0;
      res_big   <= '0;
      res_sunk  <= '0;
      res_go    <= 1'b0;
`ifdef SHOT_COUNT_EN
      shots_fired <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (score) begin
          if (bad_shot) begin
            wflag <= 1'b1;
          end else begin
            wflag  <= 1'b0;
            lx     <= x;
            ly     <= y;
            lbig   <= big;
            dx     <= big ? -3'sd2 : -3'sd1;
            dy     <= big ? -3'sd2 : -3'sd1;
            hflag  <= 1'b0;
            nflag  <= 1'b0;
            bflags <= '0;
            if (big) big_left <= big_left - 2'd1;
`ifdef SHOT_COUNT_EN
            if (shots_fired != 8'hff) shots_fired <= shots_fired + 8'd1;
`endif
          end
        end
        SCAN: begin
          if (fresh) begin
            mem[mem_idx] <= 1'b1;
            dmg[sid]     <= dmg[sid] + 3'd1;
            num_hits     <= sat_inc(num_hits);
            hflag        <= 1'b1;
            bflags       <= bflags | (5'(1) << sid);
          end else if (is_ship) begin
            nflag <= 1'b1;
          end
          if (dxi == lim) begin
            dx <= 3'(-lim);
            dy <= dy + 3'sd1;
          end else begin
            dx <= dx + 3'sd1;
          end
        end
        default: begin
          res_wrong <= wrong;
          res_hit   <= hit;
          res_near  <= near_miss;
          res_miss  <= miss;
          res_big   <= biggest_ship;
          res_sunk  <= sunk;
          res_go    <= game_over;
        end
      endcase
    end
  end

  // Results are live from scratch during REPORT and held in res_* afterwards
  always_comb begin
    busy = (state != IDLE);
    done = (state == REPORT);
    if (state == REPORT) begin
      wrong        = wflag;
      hit          = !wflag && hflag;
      near_miss    = !wflag && !hflag && nflag;
      miss         = !wflag && !hflag && !nflag;
      biggest_ship = wflag ? res_big : top_bit(bflags);
      sunk         = live_sunk;
      game_over    = &live_sunk;
    end else begin
      wrong        = res_wrong;
      hit          = res_hit;
      near_miss    = res_near;
      miss         = res_miss;
      biggest_ship = res_big;
      sunk         = res_sunk;
      game_over    = res_go;
    end
  end

endmodule

// File: tb/tb_battleship_shot_engine.sv
// Directed self-checking bench for battleship_shot_engine with hand-computed expectations.
module tb_battleship_shot_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       score = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic       big = 1'b0;
  logic       busy, done, wrong, hit, near_miss, miss, game_over;
  logic [4:0] biggest_ship, sunk, num_hits;
  logic [1:0] big_left;
`ifdef SHOT_COUNT_EN
  logic [7:0] shots_fired;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  always #5 clock = ~clock;

  battleship_shot_engine dut (
    .clock(clock), .reset(reset), .score(score), .x(x), .y(y), .big(big),
    .busy(busy), .done(done), .wrong(wrong), .hit(hit), .near_miss(near_miss),
    .miss(miss), .biggest_ship(biggest_ship), .sunk(sunk), .num_hits(num_hits),
    .big_left(big_left), .game_over(game_over)
`ifdef SHOT_COUNT_EN
    , .shots_fired(shots_fired)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fires one shot from IDLE and returns cycles until done (0 if it never came).
  // When inj > 0 a conflicting score pulse is injected that many cycles later.
  task automatic fire(input int tx, input int ty, input logic tb, input int inj, output int l);
    @(negedge clock);
    x = 4'(tx); y = 4'(ty); big = tb; score = 1'b1;
    l = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      score = (k == inj);
      if (k == inj) begin x = 4'd5; y = 4'd3; big = 1'b1; end
      if (done) begin l = k; break; end
    end
    score = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic h, input logic n, input logic m);
    chk({tag, ".hit"}, hit, h);
    chk({tag, ".near"}, near_miss, n);
    chk({tag, ".miss"}, miss, m);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.flags", {wrong, hit, near_miss, miss, game_over}, 0);
    chk("rst.big_left", big_left, 3);
    chk("rst.num_hits", num_hits, 0);
    chk("rst.sunk", sunk, 0);

    fire(7, 6, 0, 0, lat);
    chk("s1.lat", lat, 10);
    chk_res("s1", 1, 0, 0);
    chk("s1.biggest", biggest_ship, 5'b00001);
    chk("s1.num_hits", num_hits, 1);
    chk("s1.sunk", sunk, 0);
    chk("s1.busy", busy, 1);

    fire(8, 6, 0, 0, lat);
    chk_res("s2", 1, 0, 0);
    chk("s2.sunk", sunk, 5'b00001);
    chk("s2.num_hits", num_hits, 2);

    fire(8, 6, 0, 0, lat);
    chk_res("s3", 0, 1, 0);
    chk("s3.num_hits", num_hits, 2);
    chk("s3.biggest", biggest_ship, 0);

    fire(6, 5, 0, 0, lat);
    chk_res("s4", 0, 1, 0);

    fire(9, 9, 0, 3, lat);
    chk("s5.lat", lat, 10);
    chk_res("s5", 0, 0, 1);
    chk("s5.big_left", big_left, 3);

    fire(3, 2, 1, 0, lat);
    chk("b1.lat", lat, 26);
    chk_res("b1", 1, 0, 0);
    chk("b1.biggest", biggest_ship, 5'b10000);
    chk("b1.big_left", big_left, 2);
    chk("b1.num_hits", num_hits, 11);
    chk("b1.sunk", sunk, 5'b00101);
    @(negedge clock);
    chk("b1.idle_busy", busy, 0);
    chk("b1.hold_hit", hit, 1);

    fire(0, 5, 0, 0, lat);
    chk("w0.lat", lat, 1);
    chk("w0.wrong", wrong, 1);
    chk_res("w0", 0, 0, 0);
    chk("w0.num_hits", num_hits, 11);
    chk("w0.biggest", biggest_ship, 5'b10000);
    chk("w0.big_left", big_left, 2);

    fire(11, 5, 0, 0, lat);
    chk("w11.lat", lat, 1);
    chk("w11.wrong", wrong, 1);

    fire(9, 9, 1, 0, lat);
    chk("b2.lat", lat, 26);
    chk("b2.wrong", wrong, 0);
    chk_res("b2", 0, 0, 1);
    fire(9, 9, 1, 0, lat);
    chk("b3.big_left", big_left, 0);
    fire(5, 5, 1, 0, lat);
    chk("wb.lat", lat, 1);
    chk("wb.wrong", wrong, 1);
    chk("wb.big_left", big_left, 0);
    chk("wb.num_hits", num_hits, 11);

    fire(2, 8, 0, 0, lat);
    fire(2, 9, 0, 0, lat);
    fire(2, 10, 0, 0, lat);
    chk("g1.sunk", sunk, 5'b00111);
    chk("g1.biggest", biggest_ship, 5'b00010);
    fire(1, 2, 0, 0, lat);
    chk("g2.sunk", sunk, 5'b01111);
    fire(5, 3, 0, 0, lat);
    chk("g3.game_over", game_over, 0);
    fire(6, 3, 0, 0, lat);
    chk("g4.sunk", sunk, 5'b11111);
    chk("g4.game_over", game_over, 1);
    chk("g4.num_hits", num_hits, 17);
    fire(9, 9, 0, 0, lat);
    chk("g5.lat_after_over", lat, 10);
    chk_res("g5", 0, 0, 1);

    @(negedge clock);
    x = 4'd7; y = 4'd6; big = 1'b0; score = 1'b1;
    @(negedge clock);
    score = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mr.busy", busy, 0);
    chk("mr.num_hits", num_hits, 0);
    chk("mr.big_left", big_left, 3);
    chk("mr.sunk", sunk, 0);
    chk("mr.game_over", game_over, 0);
    fire(7, 6, 0, 0, lat);
    chk("mr.lat", lat, 10);
    chk_res("mr", 1, 0, 0);
    chk("mr.num_hits2", num_hits, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
